// File: rtl/axi_llc_miss_cnt_bank.sv
// In-flight miss counter bank: one counter per aliased AXI ID plus a total, with
// saturation back-pressure on new misses and a sticky flag for unmatched retirements.
module axi_llc_miss_cnt_bank #(
    parameter int unsigned IdWidth     = 6,
    parameter int unsigned UseIdBits   = 4,
    parameter int unsigned CntWidth    = 5,
    parameter int unsigned TotCntWidth = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   inc_valid_i,
    output logic                   inc_ready_o,
    input  logic [IdWidth-1:0]     inc_id_i,
    input  logic                   dec_valid_i,
    input  logic [IdWidth-1:0]     dec_id_i,
    input  logic [IdWidth-1:0]     chk_id_i,
    output logic                   chk_pending_o,
    output logic [TotCntWidth-1:0] tot_cnt_o,
    output logic                   busy_o,
    output logic                   err_o,
    input  logic                   err_clr_i
);

    localparam int unsigned IdxWidth = (UseIdBits < IdWidth) ? UseIdBits : IdWidth;
    localparam int unsigned NumCnt   = 1 << IdxWidth;
    localparam int unsigned SumWidth = TotCntWidth + IdxWidth;
    localparam logic [CntWidth-1:0]    CntMax = '1;
    localparam logic [TotCntWidth-1:0] TotMax = '1;

    if (TotCntWidth < CntWidth) begin : g_bad_tot_width
        $error("TotCntWidth must be >= CntWidth");
    end
    if (UseIdBits < 1) begin : g_bad_use_id_bits
        $error("UseIdBits must be >= 1");
    end

    logic [CntWidth-1:0]    cnt_q [NumCnt];
    logic [CntWidth-1:0]    cnt_d [NumCnt];
    logic [TotCntWidth-1:0] tot_q, tot_d;
    logic                   err_q, err_d;

    logic [IdxWidth-1:0] inc_idx, dec_idx, chk_idx;
    logic                inc_fire, dec_ok, dec_err;
    logic [NumCnt-1:0]   inc_hit, dec_hit;
    logic [SumWidth-1:0] cnt_sum;
    logic                unused_id_bits;

    assign inc_idx = inc_id_i[IdxWidth-1:0];
    assign dec_idx = dec_id_i[IdxWidth-1:0];
    assign chk_idx = chk_id_i[IdxWidth-1:0];
    assign unused_id_bits = ^{inc_id_i, dec_id_i, chk_id_i};

    // Ready looks only at registered state and the presented ID, never at any valid.
    assign inc_ready_o = (cnt_q[inc_idx] != CntMax) && (tot_q != TotMax);
    assign inc_fire    = inc_valid_i && inc_ready_o;
    assign dec_ok      = dec_valid_i && (cnt_q[dec_idx] != '0);
    assign dec_err     = dec_valid_i && !dec_ok;

    for (genvar gi = 0; gi < NumCnt; gi++) begin : g_hit
        assign inc_hit[gi] = inc_fire && (inc_idx == IdxWidth'(gi));
        assign dec_hit[gi] = dec_ok && (dec_idx == IdxWidth'(gi));
    end

    always_comb begin
        for (int i = 0; i < NumCnt; i++) begin
            cnt_d[i] = cnt_q[i] + CntWidth'(inc_hit[i]) - CntWidth'(dec_hit[i]);
        end
        tot_d = tot_q + TotCntWidth'(inc_fire) - TotCntWidth'(dec_ok);
        // A new error in the same cycle as a clear keeps the flag set.
        err_d = dec_err ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumCnt; i++) begin
                cnt_q[i] <= '0;
            end
            tot_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NumCnt; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            tot_q <= tot_d;
            err_q <= err_d;
        end
    end

    assign chk_pending_o = (cnt_q[chk_idx] != '0);
    assign tot_cnt_o     = tot_q;
    assign busy_o        = (tot_q != '0);
    assign err_o         = err_q;

    always_comb begin
        cnt_sum = '0;
        for (int i = 0; i < NumCnt; i++) begin
            cnt_sum = cnt_sum + SumWidth'(cnt_q[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (SumWidth'(tot_q) == cnt_sum);
        end
    end

endmodule

// File: tb/tb_axi_llc_miss_cnt_bank.sv
// Directed and randomized bench for the miss counter bank, checked against an
// array-of-integers model of the per-ID and total in-flight counts.
module tb_axi_llc_miss_cnt_bank;

    localparam int NCNT    = 16;
    localparam int CNT_MAX = 31;
    localparam int TOT_MAX = 127;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       inc_valid_i;
    logic       inc_ready_o;
    logic [5:0] inc_id_i;
    logic       dec_valid_i;
    logic [5:0] dec_id_i;
    logic [5:0] chk_id_i;
    logic       chk_pending_o;
    logic [6:0] tot_cnt_o;
    logic       busy_o;
    logic       err_o;
    logic       err_clr_i;

    int tests = 0;
    int fails = 0;

    int m_cnt [NCNT];
    int m_tot;
    bit m_err;
    bit m_fire;

    always #5 clk = ~clk;

    axi_llc_miss_cnt_bank dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .inc_valid_i  (inc_valid_i),
        .inc_ready_o  (inc_ready_o),
        .inc_id_i     (inc_id_i),
        .dec_valid_i  (dec_valid_i),
        .dec_id_i     (dec_id_i),
        .chk_id_i     (chk_id_i),
        .chk_pending_o(chk_pending_o),
        .tot_cnt_o    (tot_cnt_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input logic [5:0] id);
        return (m_cnt[id % NCNT] < CNT_MAX) && (m_tot < TOT_MAX);
    endfunction

    task automatic model_check();
        check("ready",   inc_ready_o,   model_ready(inc_id_i));
        check("pending", chk_pending_o, m_cnt[chk_id_i % NCNT] > 0);
        check("tot",     tot_cnt_o,     m_tot);
        check("busy",    busy_o,        m_tot > 0);
        check("err",     err_o,         m_err);
    endtask

    task automatic model_update();
        bit fire, ok;
        if (!rst_ni) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_tot  = 0;
            m_err  = 0;
            m_fire = 0;
            return;
        end
        fire = inc_valid_i && model_ready(inc_id_i);
        ok   = dec_valid_i && (m_cnt[dec_id_i % NCNT] > 0);
        if (fire) begin
            m_cnt[inc_id_i % NCNT]++;
            m_tot++;
        end
        if (ok) begin
            m_cnt[dec_id_i % NCNT]--;
            m_tot--;
        end
        if (dec_valid_i && !ok) m_err = 1;
        else if (err_clr_i)     m_err = 0;
        m_fire = fire;
    endtask

    // One clock cycle: drive, check pre-edge outputs against the model, clock, update model.
    task automatic cyc(input bit r, input bit iv, input logic [5:0] ii, input bit dv,
                       input logic [5:0] di, input logic [5:0] ci, input bit cl);
        rst_ni = r; inc_valid_i = iv; inc_id_i = ii;
        dec_valid_i = dv; dec_id_i = di; chk_id_i = ci; err_clr_i = cl;
        #1;
        if (r) model_check();
        @(posedge clk);
        model_update();
        #1;
        $display("[TB] t=%0t rst=%0b inc=%0b/%h dec=%0b/%h chk=%h clr=%0b -> tot=%0d err=%0b",
                 $time, r, iv, ii, dv, di, ci, cl, tot_cnt_o, err_o);
    endtask

    task automatic probe(input logic [5:0] ii, input logic [5:0] ci);
        rst_ni = 1; inc_valid_i = 0; dec_valid_i = 0; err_clr_i = 0;
        inc_id_i = ii; chk_id_i = ci;
        #1;
    endtask

    initial begin
        bit         hold = 0;
        bit         iv;
        logic [5:0] ii = '0;

        // 1: reset held two cycles with an increment offered
        cyc(0, 1, 6'h05, 0, 0, 0, 0);
        cyc(0, 1, 6'h05, 0, 0, 0, 0);
        for (int k = 0; k < NCNT; k++) cyc(1, 0, 6'(k), 0, 0, 6'(k), 0);
        probe(6'h05, 6'h05);
        check("rst_ready", inc_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_pending", chk_pending_o, 0);
        check("rst_err", err_o, 0);

        // 2: per-ID saturation on 0x05
        for (int k = 0; k < 31; k++) cyc(1, 1, 6'h05, 0, 0, 6'h05, 0);
        probe(6'h05, 6'h05);
        check("sat_ready5", inc_ready_o, 0);
        check("sat_tot", tot_cnt_o, 31);
        check("sat_pending5", chk_pending_o, 1);
        probe(6'h06, 6'h06);
        check("sat_ready6", inc_ready_o, 1);
        cyc(1, 1, 6'h05, 0, 0, 6'h05, 0);
        cyc(1, 0, 6'h05, 1, 6'h05, 6'h05, 0);
        probe(6'h05, 6'h05);
        check("unsat_ready5", inc_ready_o, 1);
        check("unsat_tot", tot_cnt_o, 30);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // 3: total saturation
        for (int k = 0; k < 127; k++) cyc(1, 1, 6'(k % 16), 0, 0, 6'(k % 16), 0);
        probe(6'h00, 6'h00);
        check("tot_sat", tot_cnt_o, 127);
        for (int k = 0; k < NCNT; k++) begin
            probe(6'(k), 6'(k));
            check("tot_sat_ready", inc_ready_o, 0);
        end
        cyc(1, 1, 6'h3f, 0, 0, 6'h3f, 0);
        check("tot_sat_hold", tot_cnt_o, 127);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // 4: simultaneous inc+dec on 0x02 at count 3
        for (int k = 0; k < 3; k++) cyc(1, 1, 6'h02, 0, 0, 6'h02, 0);
        cyc(1, 1, 6'h02, 1, 6'h02, 6'h02, 0);
        probe(6'h02, 6'h02);
        check("incdec_tot", tot_cnt_o, 3);
        check("incdec_pending", chk_pending_o, 1);

        // 5: underflow on 0x07, set-wins-over-clear, then clear
        probe(6'h07, 6'h07);
        check("uf_pending_pre", chk_pending_o, 0);
        cyc(1, 0, 0, 1, 6'h07, 6'h07, 0);
        probe(6'h07, 6'h07);
        check("uf_err", err_o, 1);
        check("uf_tot", tot_cnt_o, 3);
        cyc(1, 0, 0, 1, 6'h07, 6'h07, 1);
        probe(6'h07, 6'h07);
        check("uf_setwins", err_o, 1);
        cyc(1, 0, 0, 0, 0, 6'h07, 1);
        probe(6'h07, 6'h07);
        check("uf_clr", err_o, 0);

        // 6: aliasing of IDs sharing the low four bits
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 6'h13, 0, 0, 6'h03, 0);
        probe(6'h00, 6'h03);
        check("alias_pending", chk_pending_o, 1);
        check("alias_busy", busy_o, 1);
        cyc(1, 0, 0, 1, 6'h23, 6'h03, 0);
        probe(6'h00, 6'h03);
        check("alias_pending_clr", chk_pending_o, 0);
        check("alias_busy_clr", busy_o, 0);
        check("alias_err", err_o, 0);

        // Random phases alternating between fill-biased and drain-biased traffic
        for (int ph = 0; ph < 6; ph++) begin
            for (int n = 0; n < 300; n++) begin
                bit fill = (ph % 2) == 0;
                if (!hold) begin
                    iv = ($urandom_range(0, 99) < (fill ? 90 : 25));
                    ii = 6'($urandom_range(0, 63)) & 6'h37;
                end
                cyc(($urandom_range(0, 499) != 0),
                    iv, ii,
                    ($urandom_range(0, 99) < (fill ? 20 : 80)),
                    6'($urandom_range(0, 63)) & 6'h37,
                    6'($urandom_range(0, 63)),
                    ($urandom_range(0, 9) == 0));
                hold = iv && !m_fire && rst_ni;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
